add_result_accumulator: RTL and testbench
=========================================

// Module: add_result_accumulator
// PURPOSE
//   Downstream consumer of the parameterized ripple-carry adder's o_result (WIDTH+1 bits).
//   Sums COUNT consecutive adder results into one frame total, then presents the total downstream.
//   Valid/ready handshake on both sides; holds the total until downstream accepts it.
//   Flags arithmetic wrap of the accumulator per frame.
// PARAMETERS
//   WIDTH      8   operand width of the upstream adder; input sample is WIDTH+1 bits
//   COUNT      4   adder results per frame; legal range >= 1
//   ACC_WIDTH  10  accumulator/output width; legal range >= WIDTH+1
// PORTS
//   i_clk         in   1            clock; all state updates on rising edge
//   i_rst         in   1            synchronous reset, active-high
//   i_result      in   WIDTH+1      adder result {carry, sum}, unsigned
//   i_valid       in   1            i_result is valid this cycle
//   o_ready       out  1            block accepts i_result this cycle
//   o_sum         out  ACC_WIDTH    frame total, unsigned, modulo 2^ACC_WIDTH
//   o_sum_valid   out  1            o_sum/o_overflow valid
//   i_sum_ready   in   1            downstream accepts o_sum this cycle
//   o_overflow    out  1            total for this frame exceeded 2^ACC_WIDTH-1 (wrapped)
// BEHAVIOUR
//   Clocking: single clock i_clk; reset is synchronous and active-high on i_rst.
//   Reset: state=ACCUM, acc=0, cnt=0, o_sum=0, o_sum_valid=0, o_overflow=0.
//   o_ready=0 while i_rst is high; o_ready=1 in the first cycle after reset release.
//   FSM with two states:
//   - ACCUM: o_ready=1, o_sum_valid=0.
//     * Accept when i_valid&&o_ready: acc <= acc + zero-extend(i_result) and cnt <= cnt+1.
//     * The carry out of bit ACC_WIDTH-1 on any accept sets an internal wrap flag (sticky within the frame).
//     * On the accept where cnt==COUNT-1:
//       o_sum <= acc+i_result (wrapped), o_overflow <= wrap flag OR this carry,
//       o_sum_valid <= 1, state -> HOLD.
//     * No accept -> all state holds.
//   - HOLD: o_ready=0 (upstream stalls), and o_sum/o_overflow/o_sum_valid stay stable.
//     * On i_sum_ready: o_sum_valid <= 0, o_overflow <= 0, acc <= 0, cnt <= 0,
//       wrap flag <= 0, state -> ACCUM.
//     * The next sample is accepted the cycle after the HOLD exit; no bubble-free overlap.
//   Latency: o_sum_valid rises the cycle after the COUNT-th accept.
//     Minimum frame period is COUNT+1 cycles.
//   COUNT==1: every accepted sample goes straight to HOLD with o_sum = zero-extended i_result.
//   i_sum_ready while o_sum_valid=0: ignored.
//   i_valid while o_ready=0: ignored; upstream must hold data.
//   Reset mid-frame or mid-HOLD: partial sum and pending total are discarded.
//     Behaviour is identical to power-on reset.
//   i_result is treated as unsigned.
//   o_sum wraps modulo 2^ACC_WIDTH; only o_overflow reports the wrap.
// TESTING (WIDTH=8, COUNT=4, ACC_WIDTH=10)
//   1. Hold i_rst high for 3 cycles -> all outputs 0 and o_ready=0; o_ready=1 on the cycle after release.
//   2. Feed 1,2,3,4 back-to-back with i_sum_ready=1
//      -> o_sum=10, o_overflow=0, o_sum_valid high for 1 cycle, the cycle after the 4th accept.
//   3. Feed 10,20,30,40 with 2-cycle i_valid gaps -> o_sum=100; gaps do not advance cnt.
//   4. Feed 300,300,300,300 -> o_sum=176 (1200 mod 1024), o_overflow=1.
//      Next frame 1,1,1,1 -> o_sum=4, o_overflow=0.
//   5. After a frame completes, hold i_sum_ready=0 for 5 cycles with i_valid=1
//      -> o_ready=0, o_sum stable, no samples consumed.
//      Then i_sum_ready=1 -> the next frame accepts from the following cycle.
//   6. Accept 7,7, then pulse i_rst -> acc cleared.
//      Feed 5,5,5,5 -> o_sum=20, o_overflow=0.

Source files
------------

// File: rtl/add_result_accumulator_if.sv
// Handshake bundle between the adder result source, the accumulator
// and the frame-total consumer.
interface add_result_accumulator_if #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 10
);
   logic [WIDTH:0]     i_result;
   logic               i_valid;
   logic               o_ready;
   logic [ACC_WIDTH-1:0] o_sum;
   logic               o_sum_valid;
   logic               i_sum_ready;
   logic               o_overflow;

   modport master (
      output i_result, i_valid, i_sum_ready,
      input  o_ready, o_sum, o_sum_valid, o_overflow
   );

   modport slave (
      input  i_result, i_valid, i_sum_ready,
      output o_ready, o_sum, o_sum_valid, o_overflow
   );
endinterface

// File: rtl/add_result_accumulator.sv
// Sums COUNT adder results per frame and holds the total until the
// downstream consumer takes it; flags accumulator wrap per frame.
module add_result_accumulator #(
   parameter int WIDTH     = 8,
   parameter int COUNT     = 4,
   parameter int ACC_WIDTH = 10
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   add_result_accumulator_if.slave bus
);
   localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               state_q;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] acc_d;
   logic [CW-1:0]        cnt_q;
   logic                 wrap_q;
   logic                 carry_d;
   logic [ACC_WIDTH-1:0] sum_q;
   logic                 sum_valid_q;
   logic                 ovf_q;

   // Extra top bit captures the carry out of the accumulator.
   always_comb begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(bus.i_result)};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         wrap_q      <= 1'b0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (bus.i_valid) begin
                  acc_q  <= acc_d;
                  cnt_q  <= cnt_q + 1'b1;
                  wrap_q <= wrap_q | carry_d;
                  if (cnt_q == CW'(COUNT - 1)) begin
                     sum_q       <= acc_d;
                     ovf_q       <= wrap_q | carry_d;
                     sum_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.i_sum_ready) begin
                  sum_valid_q <= 1'b0;
                  ovf_q       <= 1'b0;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  wrap_q      <= 1'b0;
                  state_q     <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign bus.o_ready     = (state_q == ACCUM) && !i_rst;
   assign bus.o_sum       = sum_q;
   assign bus.o_sum_valid = sum_valid_q;
   assign bus.o_overflow  = ovf_q;
endmodule

// File: tb/tb_add_result_accumulator.sv
// Randomized scoreboard bench for add_result_accumulator against a
// frame-level arithmetic model.
module tb_add_result_accumulator;
   localparam int W  = 8;
   localparam int C  = 4;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   add_result_accumulator_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

   add_result_accumulator #(
      .WIDTH(W), .COUNT(C), .ACC_WIDTH(AW)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   typedef struct {
      logic [31:0] sum;
      logic        ovf;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned frame_sum = 0;
   int          frame_n = 0;
   bit          rand_ready = 1'b0;
   bit          fixed_ready = 1'b1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a frame total is plain integer sum of COUNT samples.
   task automatic model_accept(input int unsigned v);
      frame_sum += v;
      frame_n++;
      if (frame_n == C) begin
         q.push_back('{sum: frame_sum % (1 << AW),
                       ovf: (frame_sum >= (1 << AW))});
         frame_sum = 0;
         frame_n   = 0;
      end
   endtask

   task automatic send(input int unsigned v, output int waits);
      bit r;
      bit done;
      waits = 0;
      done  = 1'b0;
      @(negedge clk);
      bus.i_valid  = 1'b1;
      bus.i_result = v[W:0];
      for (int k = 0; k < 200 && !done; k++) begin
         #1;
         r = bus.o_ready;
         @(posedge clk);
         if (r) begin
            model_accept(v);
            done = 1'b1;
         end else begin
            waits++;
            @(negedge clk);
         end
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.i_valid  = 1'b0;
         bus.i_result = ($urandom % 512);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      repeat (n) @(negedge clk);
      frame_sum = 0;
      frame_n   = 0;
      q.delete();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      #1;
      bus.i_sum_ready = rand_ready ? 1'($urandom % 2) : fixed_ready;
   end

   // Monitor: every cycle with a presented total must match the head.
   always @(negedge clk) begin
      #2;
      if (!rst && bus.o_sum_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sum got %0d want none", bus.o_sum);
         end else begin
            check("o_sum", 32'(bus.o_sum), q[0].sum);
            check("o_overflow", 32'(bus.o_overflow), 32'(q[0].ovf));
            if (bus.i_sum_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst             = 1'b1;
      bus.i_valid     = 1'b0;
      bus.i_result    = '0;
      bus.i_sum_ready = 1'b0;

      repeat (3) begin
         @(negedge clk);
         #2;
         check("rst_ready", 32'(bus.o_ready), 32'd0);
         check("rst_sum", 32'(bus.o_sum), 32'd0);
         check("rst_valid", 32'(bus.o_sum_valid), 32'd0);
         check("rst_ovf", 32'(bus.o_overflow), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("ready_after_rst", 32'(bus.o_ready), 32'd1);

      fixed_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(i, w);
      @(negedge clk);
      bus.i_valid = 1'b0;
      #2;
      check("latency_valid", 32'(bus.o_sum_valid), 32'd1);
      @(negedge clk);
      #2;
      check("valid_one_cycle", 32'(bus.o_sum_valid), 32'd0);

      for (int i = 1; i <= 4; i++) begin
         send(10 * i, w);
         idle(2);
      end
      idle(2);

      for (int i = 0; i < 4; i++) send(300, w);
      for (int i = 0; i < 4; i++) send(1, w);
      idle(3);

      fixed_ready = 1'b0;
      for (int i = 0; i < 4; i++) send($urandom_range(0, 511), w);
      repeat (5) begin
         @(negedge clk);
         bus.i_valid  = 1'b1;
         bus.i_result = 9'd9;
         #2;
         check("stall_ready", 32'(bus.o_ready), 32'd0);
         check("stall_valid", 32'(bus.o_sum_valid), 32'd1);
      end
      @(negedge clk);
      fixed_ready = 1'b1;
      @(negedge clk);
      #2;
      check("resume_ready", 32'(bus.o_ready), 32'd1);
      check("resume_valid", 32'(bus.o_sum_valid), 32'd0);
      @(posedge clk);
      model_accept(9);
      for (int i = 0; i < 3; i++) begin
         send(9, w);
         check("no_wait", 32'(w), 32'd0);
      end
      idle(3);

      send(7, w);
      send(7, w);
      do_reset(1);
      for (int i = 0; i < 4; i++) send(5, w);
      idle(3);

      fixed_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(100, w);
      idle(2);
      do_reset(2);
      fixed_ready = 1'b1;
      @(negedge clk);
      #2;
      check("hold_reset_valid", 32'(bus.o_sum_valid), 32'd0);
      check("hold_reset_ready", 32'(bus.o_ready), 32'd1);

      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < C; i++) begin
            send($urandom_range(0, 511), w);
            idle($urandom_range(0, 2));
         end
      end
      rand_ready = 1'b0;
      fixed_ready = 1'b1;
      idle(6);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
